// File: rtl/axi_bus_pkg.sv
// Shared AXI bus definitions: ID layout helpers, encodings
// and the arbiter state type used across the interconnect.
package axi_bus_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_e;

  // Bus ID = master index prepended to the master's own ID.
  function automatic int unsigned bus_id_w(
    input int unsigned m_width,
    input int unsigned m_id
  );
    return m_id + m_width;
  endfunction

  // Master index sits in the bits above the per-master ID.
  function automatic int unsigned master_idx(
    input int unsigned id,
    input int unsigned m_id
  );
    return id >> m_id;
  endfunction

endpackage

// File: rtl/axi_rr_arbiter.sv
// Round-robin grant FSM: holds a grant until handshake,
// then hands priority to the next master after the winner.
module axi_rr_arbiter
  import axi_bus_pkg::*;
#(
  parameter int W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2**W-1:0]  req_i,
  input  logic             hs_i,
  input  logic             block_i,
  output logic [W-1:0]     sel_o,
  output logic             open_o
);

  localparam int N = 2 ** W;

  arb_state_e state_q, state_d;
  logic [W-1:0] sel_q, sel_d;
  logic [W-1:0] last_q, last_d;
  logic [W-1:0] pick;
  logic [W-1:0] idx;
  logic         found;

  // First requester after the last winner, wrapping around.
  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = last_q + W'(k);
      if (!found && req_i[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  // Grant when idle; release on the handshake.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (found && !block_i) begin
          sel_d   = pick;
          state_d = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (hs_i) begin
          last_d  = sel_q;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State, parked select and priority pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      sel_q   <= '0;
      last_q  <= W'(N - 1);
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

  assign sel_o  = sel_q;
  assign open_o = (state_q == ARB_GRANT);

endmodule

// File: rtl/axi_master_arbiter.sv
// Select generator for axi_master_switch: AW/AR round-robin,
// W steered in AW order, B/R steered from the ID master field.
module axi_master_arbiter
  import axi_bus_pkg::*;
#(
  parameter int M_WIDTH  = 2,
  parameter int M_ID     = 2,
  parameter int WQ_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2**M_WIDTH-1:0]   MASTER_WR_ADDR_VALID,
  input  logic [2**M_WIDTH-1:0]   MASTER_RD_ADDR_VALID,
  input  logic                    BUS_WR_ADDR_VALID,
  input  logic                    BUS_WR_ADDR_READY,
  input  logic                    BUS_WR_DATA_VALID,
  input  logic                    BUS_WR_DATA_READY,
  input  logic                    BUS_WR_DATA_LAST,
  input  logic [M_ID+M_WIDTH-1:0] BUS_WR_BACK_ID,
  input  logic                    BUS_RD_ADDR_VALID,
  input  logic                    BUS_RD_ADDR_READY,
  input  logic [M_ID+M_WIDTH-1:0] BUS_RD_BACK_ID,
  output logic [M_WIDTH-1:0]      wr_addr_sel,
  output logic [M_WIDTH-1:0]      wr_data_sel,
  output logic [M_WIDTH-1:0]      wr_resp_sel,
  output logic [M_WIDTH-1:0]      rd_addr_sel,
  output logic [M_WIDTH-1:0]      rd_data_sel,
  output logic                    wr_addr_open,
  output logic                    wr_data_open,
  output logic                    rd_addr_open
);

  localparam int IDW = bus_id_w(M_WIDTH, M_ID);
  localparam int AW  = $clog2(WQ_DEPTH);

  logic aw_hs, ar_hs;
  logic push, pop, do_push;
  logic full, empty;

  logic [M_WIDTH-1:0] mem_q [WQ_DEPTH];
  logic [AW-1:0]      wptr_q, wptr_d;
  logic [AW-1:0]      rptr_q, rptr_d;
  logic [AW:0]        cnt_q, cnt_d;

  assign aw_hs = BUS_WR_ADDR_VALID & BUS_WR_ADDR_READY
               & wr_addr_open;
  assign ar_hs = BUS_RD_ADDR_VALID & BUS_RD_ADDR_READY
               & rd_addr_open;

  axi_rr_arbiter #(.W(M_WIDTH)) u_aw_arb (
    .clk     (clk),
    .rst     (rst),
    .req_i   (MASTER_WR_ADDR_VALID),
    .hs_i    (aw_hs),
    .block_i (full),
    .sel_o   (wr_addr_sel),
    .open_o  (wr_addr_open)
  );

  axi_rr_arbiter #(.W(M_WIDTH)) u_ar_arb (
    .clk     (clk),
    .rst     (rst),
    .req_i   (MASTER_RD_ADDR_VALID),
    .hs_i    (ar_hs),
    .block_i (1'b0),
    .sel_o   (rd_addr_sel),
    .open_o  (rd_addr_open)
  );

  assign full  = (cnt_q == (AW+1)'(WQ_DEPTH));
  assign empty = (cnt_q == '0);
  assign push  = aw_hs;
  assign pop   = BUS_WR_DATA_VALID & BUS_WR_DATA_READY
               & BUS_WR_DATA_LAST & ~empty;
  assign do_push = push & (~full | pop);

  // Order FIFO pointer and occupancy update.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (pop)     rptr_d = rptr_q + 1'b1;
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(pop);
  end

  // Order FIFO control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Order FIFO storage; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wr_addr_sel;
  end

  assign wr_data_sel  = empty ? '0 : mem_q[rptr_q];
  assign wr_data_open = ~empty;

  assign wr_resp_sel = M_WIDTH'(master_idx(
    32'(BUS_WR_BACK_ID), M_ID));
  assign rd_data_sel = M_WIDTH'(master_idx(
    32'(BUS_RD_BACK_ID), M_ID));

endmodule

// File: tb/tb_axi_master_arbiter.sv
// Bench for axi_master_arbiter: directed scenarios with literal
// expectations plus random traffic against a queue-based model.
module tb_axi_master_arbiter;

  localparam int MW = 2;
  localparam int MI = 2;
  localparam int DEPTH = 4;
  localparam int N = 1 << MW;

  logic clk;
  logic rst;
  logic [N-1:0] m_wr_v, m_rd_v;
  logic aw_v, aw_r, w_v, w_r, w_last, ar_v, ar_r;
  logic [MI+MW-1:0] b_id, r_id;
  logic [MW-1:0] wr_addr_sel, wr_data_sel, wr_resp_sel;
  logic [MW-1:0] rd_addr_sel, rd_data_sel;
  logic wr_addr_open, wr_data_open, rd_addr_open;

  int checks = 0;
  int failures = 0;

  // model state
  bit m_aw_busy, m_ar_busy;
  int m_aw_sel, m_aw_last, m_ar_sel, m_ar_last;
  int q[$];

  axi_master_arbiter #(
    .M_WIDTH(MW), .M_ID(MI), .WQ_DEPTH(DEPTH)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .MASTER_WR_ADDR_VALID (m_wr_v),
    .MASTER_RD_ADDR_VALID (m_rd_v),
    .BUS_WR_ADDR_VALID    (aw_v),
    .BUS_WR_ADDR_READY    (aw_r),
    .BUS_WR_DATA_VALID    (w_v),
    .BUS_WR_DATA_READY    (w_r),
    .BUS_WR_DATA_LAST     (w_last),
    .BUS_WR_BACK_ID       (b_id),
    .BUS_RD_ADDR_VALID    (ar_v),
    .BUS_RD_ADDR_READY    (ar_r),
    .BUS_RD_BACK_ID       (r_id),
    .wr_addr_sel          (wr_addr_sel),
    .wr_data_sel          (wr_data_sel),
    .wr_resp_sel          (wr_resp_sel),
    .rd_addr_sel          (rd_addr_sel),
    .rd_data_sel          (rd_data_sel),
    .wr_addr_open         (wr_addr_open),
    .wr_data_open         (wr_data_open),
    .rd_addr_open         (rd_addr_open)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t",
               n, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r,
                                 input int last);
    for (int k = 1; k <= N; k++) begin
      int m;
      m = (last + k) % N;
      if (r[m]) return m;
    end
    return -1;
  endfunction

  // Advance the model by one clock using pre-edge inputs.
  task automatic model_step();
    bit aw_hs, ar_hs, pop, full;
    int p;
    if (rst) begin
      m_aw_busy = 0; m_aw_sel = 0; m_aw_last = N - 1;
      m_ar_busy = 0; m_ar_sel = 0; m_ar_last = N - 1;
      q.delete();
      return;
    end
    aw_hs = m_aw_busy && aw_v && aw_r;
    ar_hs = m_ar_busy && ar_v && ar_r;
    pop = (q.size() > 0) && w_v && w_r && w_last;
    full = (q.size() == DEPTH);
    if (pop) void'(q.pop_front());
    if (!m_aw_busy) begin
      p = rr_pick(m_wr_v, m_aw_last);
      if (p >= 0 && !full) begin
        m_aw_sel = p; m_aw_busy = 1;
      end
    end else if (aw_hs) begin
      q.push_back(m_aw_sel);
      m_aw_last = m_aw_sel;
      m_aw_busy = 0;
    end
    if (!m_ar_busy) begin
      p = rr_pick(m_rd_v, m_ar_last);
      if (p >= 0) begin
        m_ar_sel = p; m_ar_busy = 1;
      end
    end else if (ar_hs) begin
      m_ar_last = m_ar_sel;
      m_ar_busy = 0;
    end
  endtask

  task automatic compare_all();
    chk("aw_sel", wr_addr_sel, m_aw_sel);
    chk("aw_open", wr_addr_open, m_aw_busy);
    chk("ar_sel", rd_addr_sel, m_ar_sel);
    chk("ar_open", rd_addr_open, m_ar_busy);
    chk("w_open", wr_data_open, q.size() != 0);
    chk("w_sel", wr_data_sel, q.size() != 0 ? q[0] : 0);
    chk("b_sel", wr_resp_sel, int'(b_id) >> MI);
    chk("r_sel", rd_data_sel, int'(r_id) >> MI);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic quiet();
    m_wr_v = '0; m_rd_v = '0;
    aw_v = 0; aw_r = 0; ar_v = 0; ar_r = 0;
    w_v = 0; w_r = 0; w_last = 0;
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0;
  endtask

  initial begin
    int exp_rr [6];
    int g;
    exp_rr = '{0, 1, 3, 0, 1, 3};
    rst = 1;
    quiet();
    b_id = '0; r_id = '0;
    tick();
    tick();
    rst = 0;
    chk("rst_aw_sel", wr_addr_sel, 0);
    chk("rst_w_sel", wr_data_sel, 0);
    chk("rst_ar_sel", rd_addr_sel, 0);
    chk("rst_aw_open", wr_addr_open, 0);
    chk("rst_w_open", wr_data_open, 0);
    chk("rst_ar_open", rd_addr_open, 0);

    // single request from master 2
    m_wr_v = 4'b0100;
    tick();
    chk("m2_grant_sel", wr_addr_sel, 2);
    chk("m2_grant_open", wr_addr_open, 1);
    m_wr_v = '0; aw_v = 1; aw_r = 1;
    tick();
    chk("m2_hs_open", wr_addr_open, 0);
    chk("m2_w_sel", wr_data_sel, 2);
    chk("m2_w_open", wr_data_open, 1);
    aw_v = 0; aw_r = 0;
    w_v = 1; w_r = 1; w_last = 1;
    tick();
    chk("m2_w_drain", wr_data_open, 0);
    quiet();

    // continuous requesters 0,1,3
    do_reset();
    m_wr_v = 4'b1011; aw_v = 1; aw_r = 1;
    w_v = 1; w_r = 1; w_last = 1;
    g = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (wr_addr_open && g < 6) begin
        chk("rr_order", wr_addr_sel, exp_rr[g]);
        g++;
      end
    end
    chk("rr_count", g, 6);
    quiet();

    // W bursts of 4 and 2 after grants to 1 then 3
    do_reset();
    m_wr_v = 4'b0010; aw_v = 1; aw_r = 1;
    tick();
    m_wr_v = 4'b1000;
    tick();
    tick();
    m_wr_v = '0;
    tick();
    aw_v = 0; aw_r = 0;
    w_v = 1; w_r = 1;
    for (int b = 0; b < 4; b++) begin
      w_last = (b == 3);
      #1 chk("burst_a_sel", wr_data_sel, 1);
      tick();
    end
    for (int b = 0; b < 2; b++) begin
      w_last = (b == 1);
      #1 chk("burst_b_sel", wr_data_sel, 3);
      tick();
    end
    chk("burst_done_open", wr_data_open, 0);
    quiet();

    // order FIFO full blocks AW grants
    do_reset();
    m_wr_v = 4'b0001; aw_v = 1; aw_r = 1;
    for (int i = 0; i < 8; i++) tick();
    tick();
    chk("full_block1", wr_addr_open, 0);
    tick();
    chk("full_block2", wr_addr_open, 0);
    w_v = 1; w_r = 1; w_last = 1;
    tick();
    w_v = 0; w_r = 0; w_last = 0;
    chk("full_pop_same", wr_addr_open, 0);
    tick();
    chk("full_regrant", wr_addr_open, 1);
    chk("full_regrant_sel", wr_addr_sel, 0);
    quiet();

    // ID-field decode
    b_id = 4'b10_01; r_id = 4'b11_00;
    #1;
    chk("b_decode", wr_resp_sel, 2);
    chk("r_decode", rd_data_sel, 3);

    // reset during GRANT with two entries queued
    do_reset();
    m_wr_v = 4'b1000; aw_v = 1; aw_r = 1;
    tick(); tick(); tick(); tick();
    aw_v = 0;
    tick();
    chk("pre_rst_open", wr_addr_open, 1);
    chk("pre_rst_q", wr_data_open, 1);
    rst = 1;
    tick();
    rst = 0;
    chk("mid_rst_aw_open", wr_addr_open, 0);
    chk("mid_rst_w_open", wr_data_open, 0);
    chk("mid_rst_ar_open", rd_addr_open, 0);
    m_wr_v = 4'b1111;
    tick();
    chk("post_rst_sel", wr_addr_sel, 0);
    chk("post_rst_open", wr_addr_open, 1);
    quiet();

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      m_wr_v = N'($urandom);
      m_rd_v = N'($urandom);
      aw_v = 1'($urandom); aw_r = 1'($urandom);
      ar_v = 1'($urandom); ar_r = 1'($urandom);
      w_v = 1'($urandom); w_r = ($urandom_range(0, 3) != 0);
      w_last = ($urandom_range(0, 2) == 0);
      b_id = (MI+MW)'($urandom);
      r_id = (MI+MW)'($urandom);
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 0;

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
